io_ctrl: RTL and testbench
==========================

Name: io_ctrl

Overview:
Parametrised memory-mapped peripheral port block for the AVR soft core. It sits between the CPU data bus (`a`/`o`/`r`/`w`, combinational read-back `p`) and the SD controller, video and keyboard. It supersedes the single-byte keyboard latch and 8-bit timer with these features:
- a keyboard FIFO with overflow flag;
- a wide, atomically readable tick timer;
- a configurable base address;
- a masked, sticky interrupt controller driving one `irq` line.

Parameters:
BASE, 16'h0020, address of offset +0; all registers live at BASE+0..BASE+8.
KF_DEPTH, 8, keyboard FIFO depth in entries; power of two, 2..64.
CLK_HZ, 25000000, clock frequency in Hz.
TICK_HZ, 100, timer tick rate in Hz; prescaler terminal count = CLK_HZ/TICK_HZ-1.
TMR_W, 16, tick counter width; 9..16.

Ports:
clock  in  1  system clock, all logic on rising edge
reset_n  in  1  synchronous reset, active low
a  in  16  port address
o  in  8  write data
r  in  1  read strobe, one cycle per access
w  in  8→1  write strobe, one cycle per access (width 1)
p  out  8  read data, combinational from a
irq  out  1  registered interrupt request
sd_command  out  1  one-cycle SD start pulse
sd_rw  out  1  0 read, 1 write
sd_lba  out  32  sector address
sd_card  in  2  card type
sd_error  in  4  SD error code
sd_done  in  1  one-cycle completion pulse
sd_busy  in  1  SD controller busy
p_vpage  out  1  video page, 0=$8000, 1=$A000
p_border  out  3  border colour
p_vblank  in  1  one-cycle frame pulse
p_kdone  in  1  one-cycle key-valid pulse
p_ascii  in  8  key code, valid with p_kdone

Behaviour:
Reset:
- Applied when reset_n=0 at a rising edge.
- All outputs and state are cleared: FIFO empty, overflow=0, prescaler=0, timer=0, shadow=0, mask=0, pending=0, irq=0, sd_command=0, sd_rw=0, sd_lba=0, p_vpage=0, p_border=0.
- Reset overrides any r/w in the same cycle.

Read map (offset from BASE; `p` is combinational, side effects occur at the clock edge where r=1):
- +0 KDATA: FIFO head, or 0 if empty. Read pops one entry; pop when empty does nothing.
- +1 KSTAT: {ovf, 7'(count)}. Read clears ovf.
- +2 TMR_L: timer[7:0]. Read copies timer[TMR_W-1:8] into shadow.
- +3 TMR_H: shadow, zero-extended; no side effect.
- +4 SDSTAT: {sd_busy, pend[2], sd_card, sd_error}. Read clears pend[2].
- +5 IMASK.
- +6 IPEND.
- Any other address returns 8'h00.

Write map:
- +0 p_border<=o[2:0].
- +1 p_vpage<=o[0].
- +2..+5 sd_lba bytes 0..3.
- +6 SD command: if sd_busy=0, sd_command pulses 1 for one cycle and sd_rw<=o[0]. If sd_busy=1 the write is ignored entirely.
- +7 IMASK<=o[3:0].
- +8 IACK: write-1-to-clear pend bits.

Keyboard FIFO:
- p_kdone pushes p_ascii.
- Full with no pop: byte dropped, ovf<=1.
- Push and pop in the same cycle (including when full): both occur, count unchanged, no overflow.
- count ranges 0..KF_DEPTH.

Timer:
- Prescaler counts 0..CLK_HZ/TICK_HZ-1, then wraps to 0.
- On wrap, timer increments modulo 2^TMR_W.

Interrupts (pend[3:0]):
- Sources: 0 key push accepted, 1 p_vblank, 2 sd_done, 3 timer tick.
- Bits are sticky. A set and a clear (IACK or SDSTAT read) in the same cycle: set wins.
- irq <= |(pend & IMASK), so irq has 1-cycle latency from the pend/mask change.

sd_command is 0 in every cycle without a qualifying write.

Decomposition:
- Shared package io_pkg holds:
  - register offset constants: KDATA, KSTAT, TMR_L, TMR_H, SDSTAT, IMASK, IPEND, LBA0..3, SDCMD, IACK;
  - IRQ bit indices: IRQ_KEY=0, IRQ_VBL=1, IRQ_SD=2, IRQ_TICK=3.
- Sub-module io_fifo: parametrised synchronous FIFO (DEPTH, W=8) with push/pop/full/empty/count.

Test Plan:
- Reset mid-operation: with a 3-entry FIFO, mask=4'hF and pending bits set, pulse reset_n=0 → next cycle count=0, irq=0, p at KDATA=0, sd_lba=0.
- Keyboard overflow (KF_DEPTH=8): push 9 bytes 'A'..'I' → KSTAT=8'h88. Read KSTAT again → 8'h08. Then 8 KDATA reads → 'A'..'H'. 9th read → 0.
- Full-FIFO push+pop: full FIFO, p_kdone with r at KDATA in the same cycle → old head returned, count stays 8, ovf stays 0.
- Timer atomicity (CLK_HZ=1000, TICK_HZ=100): run to timer=16'h00FF, read TMR_L (=8'hFF), let 10 clocks pass (timer→16'h0100), read TMR_H → 8'h00, not 8'h01.
- SD command handling:
  - LBA bytes 12,34,56,78, write +6 with o=1 while sd_busy=0 → one-cycle sd_command, sd_rw=1, sd_lba=32'h78563412.
  - Repeat with sd_busy=1 → no pulse, sd_rw unchanged.
- IRQ: IMASK=4'b0010, p_vblank pulse → irq=1 one cycle after pend set. IACK o=2 coinciding with a new p_vblank → pend[1] stays 1. IACK alone → irq=0 next cycle.

Source files
------------

// File: rtl/io_pkg.sv
// Shared register map and interrupt bit positions for the io_ctrl port block.
// Offsets are relative to the block's BASE address.
package io_pkg;

    typedef logic [3:0] off_t;

    // Read-side offsets
    localparam off_t KDATA  = 4'd0;
    localparam off_t KSTAT  = 4'd1;
    localparam off_t TMR_L  = 4'd2;
    localparam off_t TMR_H  = 4'd3;
    localparam off_t SDSTAT = 4'd4;
    localparam off_t IMASK  = 4'd5;
    localparam off_t IPEND  = 4'd6;

    // Write-side offsets
    localparam off_t BORDER  = 4'd0;
    localparam off_t VPAGE   = 4'd1;
    localparam off_t LBA0    = 4'd2;
    localparam off_t LBA1    = 4'd3;
    localparam off_t LBA2    = 4'd4;
    localparam off_t LBA3    = 4'd5;
    localparam off_t SDCMD   = 4'd6;
    localparam off_t IMASK_W = 4'd7;
    localparam off_t IACK    = 4'd8;

    localparam off_t OFF_LAST = 4'd8;

    localparam int IRQ_KEY  = 0;
    localparam int IRQ_VBL  = 1;
    localparam int IRQ_SD   = 2;
    localparam int IRQ_TICK = 3;

    typedef struct packed {
        logic tick;
        logic sd;
        logic vbl;
        logic key;
    } irq_vec_t;

endpackage

// File: rtl/io_fifo.sv
// Small synchronous FIFO used for the keyboard buffer.
// A pop on an empty FIFO is ignored; a push while full only lands if a pop frees a slot.
module io_fifo
    import io_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_FULL);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : mem[rp];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wp <= wp + AW'(1);
            end
            if (do_pop) begin
                rp <= rp + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (AW+1)'(1);
            end else if (!do_push && do_pop) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset_n && do_push) begin
            mem[wp] <= din;
        end
    end

endmodule

// File: rtl/io_ctrl.sv
// Memory-mapped peripheral port block: keyboard FIFO, tick timer,
// SD command registers, video controls and a masked sticky interrupt line.
module io_ctrl
    import io_pkg::*;
#(
    parameter logic [15:0] BASE     = 16'h0020,
    parameter int          KF_DEPTH = 8,
    parameter int          CLK_HZ   = 25000000,
    parameter int          TICK_HZ  = 100,
    parameter int          TMR_W    = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] a,
    input  logic [7:0]  o,
    input  logic        r,
    input  logic        w,
    output logic [7:0]  p,
    output logic        irq,
    output logic        sd_command,
    output logic        sd_rw,
    output logic [31:0] sd_lba,
    input  logic [1:0]  sd_card,
    input  logic [3:0]  sd_error,
    input  logic        sd_done,
    input  logic        sd_busy,
    output logic        p_vpage,
    output logic [2:0]  p_border,
    input  logic        p_vblank,
    input  logic        p_kdone,
    input  logic [7:0]  p_ascii
);

    localparam int KW      = $clog2(KF_DEPTH);
    localparam int PRE_MAX = CLK_HZ / TICK_HZ - 1;
    localparam int PW      = (PRE_MAX > 0) ? $clog2(PRE_MAX + 1) : 1;
    localparam logic [PW-1:0] PRE_TC = PW'(PRE_MAX);

    logic [15:0] rel;
    logic        hit;
    off_t        off;
    logic        rd;
    logic        wr;

    assign rel = a - BASE;
    assign hit = (rel <= 16'(OFF_LAST));
    assign off = rel[3:0];
    assign rd  = r & hit;
    assign wr  = w & hit;

    logic rd_kdata;
    logic rd_kstat;
    logic rd_tmrl;
    logic rd_sdstat;
    logic wr_sdcmd;
    logic wr_iack;

    assign rd_kdata  = rd & (off == KDATA);
    assign rd_kstat  = rd & (off == KSTAT);
    assign rd_tmrl   = rd & (off == TMR_L);
    assign rd_sdstat = rd & (off == SDSTAT);
    assign wr_sdcmd  = wr & (off == SDCMD);
    assign wr_iack   = wr & (off == IACK);

    logic [7:0]  khead;
    logic        kfull;
    logic        kempty;
    logic [KW:0] kcount;
    logic        kpop;
    logic        kacc;
    logic        ovf_set;
    logic        ovf;

    // A push into a full FIFO still lands when the same edge pops the head.
    assign kpop    = rd_kdata & ~kempty;
    assign kacc    = p_kdone & (~kfull | kpop);
    assign ovf_set = p_kdone & kfull & ~kpop;

    io_fifo #(
        .DEPTH (KF_DEPTH),
        .W     (8)
    ) u_kfifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (p_kdone),
        .pop     (rd_kdata),
        .din     (p_ascii),
        .head    (khead),
        .full    (kfull),
        .empty   (kempty),
        .count   (kcount)
    );

    logic [PW-1:0]      pre;
    logic               tick;
    logic [TMR_W-1:0]   timer;
    logic [TMR_W-9:0]   shadow;

    assign tick = (pre == PRE_TC);

    logic [3:0] mask;
    logic [3:0] pend;
    irq_vec_t   pend_set;
    logic [3:0] pend_clr;

    always_comb begin
        pend_set      = '0;
        pend_set.key  = kacc;
        pend_set.vbl  = p_vblank;
        pend_set.sd   = sd_done;
        pend_set.tick = tick;
    end

    always_comb begin
        pend_clr = '0;
        if (wr_iack) begin
            pend_clr = o[3:0];
        end
        if (rd_sdstat) begin
            pend_clr[IRQ_SD] = 1'b1;
        end
    end

    always_comb begin
        p = 8'h00;
        if (hit) begin
            unique case (off)
                KDATA:   p = khead;
                KSTAT:   p = {ovf, 7'(kcount)};
                TMR_L:   p = timer[7:0];
                TMR_H:   p = 8'(shadow);
                SDSTAT:  p = {sd_busy, pend[IRQ_SD], sd_card, sd_error};
                IMASK:   p = {4'h0, mask};
                IPEND:   p = {4'h0, pend};
                default: p = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pre    <= '0;
            timer  <= '0;
            shadow <= '0;
            ovf    <= 1'b0;
        end else begin
            pre <= tick ? '0 : pre + PW'(1);
            if (tick) begin
                timer <= timer + TMR_W'(1);
            end
            // High byte is frozen here so a later TMR_H read pairs with this low byte.
            if (rd_tmrl) begin
                shadow <= timer[TMR_W-1:8];
            end
            ovf <= ovf_set | (ovf & ~rd_kstat);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            mask <= '0;
            pend <= '0;
            irq  <= 1'b0;
        end else begin
            pend <= pend_set | (pend & ~pend_clr);
            irq  <= |(pend & mask);
            if (wr && off == IMASK_W) begin
                mask <= o[3:0];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sd_command <= 1'b0;
            sd_rw      <= 1'b0;
            sd_lba     <= '0;
            p_vpage    <= 1'b0;
            p_border   <= '0;
        end else begin
            sd_command <= wr_sdcmd & ~sd_busy;
            if (wr_sdcmd && !sd_busy) begin
                sd_rw <= o[0];
            end
            if (wr) begin
                unique case (off)
                    BORDER:  p_border      <= o[2:0];
                    VPAGE:   p_vpage       <= o[0];
                    LBA0:    sd_lba[7:0]   <= o;
                    LBA1:    sd_lba[15:8]  <= o;
                    LBA2:    sd_lba[23:16] <= o;
                    LBA3:    sd_lba[31:24] <= o;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_io_ctrl.sv
// Self-checking bench for io_ctrl: directed vector table, corner sequences
// and randomized traffic compared against a queue-based reference model.
module tb_io_ctrl;

    localparam logic [15:0] BASE = 16'h0020;
    localparam int KF = 8;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] a = BASE;
    logic [7:0]  o = 8'h00;
    logic        r = 1'b0;
    logic        w = 1'b0;
    logic [7:0]  p;
    logic        irq;
    logic        sd_command;
    logic        sd_rw;
    logic [31:0] sd_lba;
    logic [1:0]  sd_card = 2'b10;
    logic [3:0]  sd_error = 4'h5;
    logic        sd_done = 1'b0;
    logic        sd_busy = 1'b0;
    logic        p_vpage;
    logic [2:0]  p_border;
    logic        p_vblank = 1'b0;
    logic        p_kdone = 1'b0;
    logic [7:0]  p_ascii = 8'h00;

    always #5 clock = ~clock;

    io_ctrl #(
        .BASE     (BASE),
        .KF_DEPTH (KF),
        .CLK_HZ   (1000),
        .TICK_HZ  (100),
        .TMR_W    (16)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .a          (a),
        .o          (o),
        .r          (r),
        .w          (w),
        .p          (p),
        .irq        (irq),
        .sd_command (sd_command),
        .sd_rw      (sd_rw),
        .sd_lba     (sd_lba),
        .sd_card    (sd_card),
        .sd_error   (sd_error),
        .sd_done    (sd_done),
        .sd_busy    (sd_busy),
        .p_vpage    (p_vpage),
        .p_border   (p_border),
        .p_vblank   (p_vblank),
        .p_kdone    (p_kdone),
        .p_ascii    (p_ascii)
    );

    int n_chk = 0;
    int n_pass = 0;

    // Reference model: the timer is just edges-since-reset divided by 10.
    logic [7:0]  q[$];
    int          mk;
    logic        m_ovf;
    logic [7:0]  m_shadow;
    logic [3:0]  m_mask;
    logic [3:0]  m_pend;
    logic        m_irq;
    logic [2:0]  m_border;
    logic        m_vpage;
    logic [31:0] m_lba;
    logic        m_rw;
    logic        m_cmd;
    logic        pre_on = 1'b0;
    logic [7:0]  last_p;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        else
            n_pass++;
    endtask

    function automatic logic [7:0] exp_p();
        logic [15:0] d;
        logic [15:0] tm;
        d  = a - BASE;
        tm = 16'(mk / 10);
        case (d)
            16'd0:   return (q.size() > 0) ? q[0] : 8'h00;
            16'd1:   return {m_ovf, 7'(q.size())};
            16'd2:   return tm[7:0];
            16'd3:   return m_shadow;
            16'd4:   return {sd_busy, m_pend[2], sd_card, sd_error};
            16'd5:   return {4'h0, m_mask};
            16'd6:   return {4'h0, m_pend};
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_update();
        logic [15:0] d;
        logic [15:0] tm;
        logic        rd;
        logic        wr;
        logic        kacc;
        logic        oset;
        logic        tk;
        logic [3:0]  clr;
        int          bi;
        if (!reset_n) begin
            q.delete();
            mk = 0; m_ovf = 0; m_shadow = 0; m_mask = 0; m_pend = 0;
            m_irq = 0; m_border = 0; m_vpage = 0; m_lba = 0;
            m_rw = 0; m_cmd = 0;
            return;
        end
        d  = a - BASE;
        tm = 16'(mk / 10);
        rd = r && (d <= 16'd8);
        wr = w && (d <= 16'd8);
        kacc = 0;
        oset = 0;
        if (rd && d == 16'd0 && q.size() > 0) void'(q.pop_front());
        if (p_kdone) begin
            if (q.size() < KF) begin
                q.push_back(p_ascii);
                kacc = 1;
            end else begin
                oset = 1;
            end
        end
        m_ovf = oset | (m_ovf & !(rd && d == 16'd1));
        if (rd && d == 16'd2) m_shadow = tm[15:8];
        tk = (mk % 10) == 9;
        mk++;
        clr = 4'h0;
        if (wr && d == 16'd8) clr = o[3:0];
        if (rd && d == 16'd4) clr[2] = 1'b1;
        m_irq  = |(m_pend & m_mask);
        m_pend = {tk, sd_done, p_vblank, kacc} | (m_pend & ~clr);
        m_cmd  = wr && d == 16'd6 && !sd_busy;
        if (m_cmd) m_rw = o[0];
        if (wr) begin
            if (d == 16'd0) m_border = o[2:0];
            if (d == 16'd1) m_vpage = o[0];
            if (d >= 16'd2 && d <= 16'd5) begin
                bi = int'(d) - 2;
                m_lba[8*bi +: 8] = o;
            end
            if (d == 16'd7) m_mask = o[3:0];
        end
    endtask

    task automatic step();
        #1;
        last_p = p;
        if (pre_on) chk("p_read", {24'h0, p}, {24'h0, exp_p()});
        @(posedge clock);
        model_update();
        #1;
        pre_on = 1'b1;
        chk("irq", {31'h0, irq}, {31'h0, m_irq});
        chk("sd_command", {31'h0, sd_command}, {31'h0, m_cmd});
        chk("sd_rw", {31'h0, sd_rw}, {31'h0, m_rw});
        chk("sd_lba", sd_lba, m_lba);
        chk("p_vpage", {31'h0, p_vpage}, {31'h0, m_vpage});
        chk("p_border", {29'h0, p_border}, {29'h0, m_border});
    endtask

    task automatic idle();
        r = 0; w = 0; p_kdone = 0; p_vblank = 0; sd_done = 0;
    endtask

    task automatic do_reset();
        idle();
        reset_n = 0;
        step();
        reset_n = 1;
    endtask

    task automatic wr_reg(input int off, input logic [7:0] val);
        a = BASE + 16'(off); o = val; w = 1;
        step();
        w = 0;
    endtask

    task automatic push_key(input logic [7:0] c);
        p_kdone = 1; p_ascii = c;
        step();
        p_kdone = 0;
    endtask

    typedef struct {
        int         off;
        logic       rd;
        logic       kd;
        logic [7:0] asc;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[$];

    initial begin
        vec_t v;
        int   guard;
        int   sel;
        int   op;

        for (int i = 0; i < 9; i++) begin
            v = '{1, 1'b0, 1'b1, 8'h41 + 8'(i), {1'b0, 7'(i)}};
            tbl.push_back(v);
        end
        tbl.push_back('{1, 1'b1, 1'b0, 8'h00, 8'h88});
        tbl.push_back('{1, 1'b1, 1'b0, 8'h00, 8'h08});
        for (int i = 0; i < 8; i++) begin
            v = '{0, 1'b1, 1'b0, 8'h00, 8'h41 + 8'(i)};
            tbl.push_back(v);
        end
        tbl.push_back('{0, 1'b1, 1'b0, 8'h00, 8'h00});

        // Reset state
        do_reset();
        a = BASE + 16'd1;
        step();
        chk("reset_kstat", {24'h0, last_p}, 32'h0);
        chk("reset_irq", {31'h0, irq}, 32'h0);
        chk("reset_lba", sd_lba, 32'h0);

        // Keyboard overflow table
        do_reset();
        foreach (tbl[i]) begin
            a = BASE + 16'(tbl[i].off);
            r = tbl[i].rd;
            p_kdone = tbl[i].kd;
            p_ascii = tbl[i].asc;
            step();
            chk($sformatf("tbl%0d", i), {24'h0, last_p}, {24'h0, tbl[i].exp});
        end
        idle();

        // Reset in the middle of activity
        do_reset();
        wr_reg(2, 8'h55);
        push_key(8'h31); push_key(8'h32); push_key(8'h33);
        wr_reg(7, 8'h0F);
        step();
        chk("pre_rst_irq", {31'h0, irq}, 32'h1);
        do_reset();
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_lba", sd_lba, 32'h0);
        a = BASE; step();
        chk("rst_kdata", {24'h0, last_p}, 32'h0);
        a = BASE + 16'd1; step();
        chk("rst_kstat", {24'h0, last_p}, 32'h0);

        // Push and pop on a full FIFO in the same cycle
        do_reset();
        for (int i = 0; i < KF; i++) push_key(8'h30 + 8'(i));
        a = BASE; r = 1; p_kdone = 1; p_ascii = 8'h5A;
        step();
        chk("full_pp_head", {24'h0, last_p}, 32'h30);
        idle();
        a = BASE + 16'd1; step();
        chk("full_pp_kstat", {24'h0, last_p}, 32'h08);

        // Timer high byte is latched by the low-byte read
        do_reset();
        guard = 0;
        while (mk / 10 != 255 && guard < 4000) begin
            step();
            guard++;
        end
        chk("tmr_reach", {31'h0, guard < 4000}, 32'h1);
        a = BASE + 16'd2; r = 1; step();
        chk("tmr_l_ff", {24'h0, last_p}, 32'hFF);
        r = 0;
        for (int i = 0; i < 10; i++) step();
        a = BASE + 16'd3; r = 1; step();
        chk("tmr_h_shadow", {24'h0, last_p}, 32'h00);
        a = BASE + 16'd2; r = 0; step();
        chk("tmr_l_wrap", {24'h0, last_p}, 32'h00);

        // SD command
        do_reset();
        wr_reg(2, 8'h12); wr_reg(3, 8'h34); wr_reg(4, 8'h56); wr_reg(5, 8'h78);
        sd_busy = 0;
        wr_reg(6, 8'h01);
        chk("sd_pulse", {31'h0, sd_command}, 32'h1);
        chk("sd_rw1", {31'h0, sd_rw}, 32'h1);
        chk("sd_lba_val", sd_lba, 32'h78563412);
        step();
        chk("sd_pulse_end", {31'h0, sd_command}, 32'h0);
        sd_busy = 1;
        wr_reg(6, 8'h00);
        chk("sd_busy_nopulse", {31'h0, sd_command}, 32'h0);
        chk("sd_busy_rw", {31'h0, sd_rw}, 32'h1);
        sd_busy = 0;

        // Interrupt set/clear ordering
        do_reset();
        wr_reg(7, 8'h02);
        p_vblank = 1; step(); p_vblank = 0;
        chk("irq_lat0", {31'h0, irq}, 32'h0);
        step();
        chk("irq_lat1", {31'h0, irq}, 32'h1);
        p_vblank = 1; wr_reg(8, 8'h02); p_vblank = 0;
        a = BASE + 16'd6; step();
        chk("iack_setwins", {31'h0, last_p[1]}, 32'h1);
        wr_reg(8, 8'h02);
        step();
        chk("irq_cleared", {31'h0, irq}, 32'h0);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            sel = $urandom_range(0, 11);
            if (sel <= 8) a = BASE + 16'(sel);
            else if (sel == 9) a = BASE - 16'd1;
            else if (sel == 10) a = BASE + 16'd9;
            else a = 16'($urandom);
            op = $urandom_range(0, 9);
            r = (op < 4);
            w = (op == 4);
            o = 8'($urandom);
            p_kdone = ($urandom_range(0, 2) == 0);
            p_ascii = 8'($urandom);
            p_vblank = ($urandom_range(0, 19) == 0);
            sd_done = ($urandom_range(0, 19) == 0);
            sd_busy = 1'($urandom_range(0, 1));
            reset_n = ($urandom_range(0, 499) != 0);
            step();
        end
        reset_n = 1;
        idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
